// File: rtl/ahb_lite_master.sv
// Single-initiator AHB-Lite master: valid/ready commands in, pipelined single-word transfers out.
// Define RD_PARITY_CHECK_EN to flag bit-16 parity errors on read data; otherwise rsp_perr is tied low.
module ahb_lite_master #(
  parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
  parameter logic [2:0]  HSIZE_WORD = 3'b010
) (
  input  logic        HCLK,
  input  logic        HRESET,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_write,
  input  logic [31:0] cmd_addr,
  input  logic [31:0] cmd_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        rsp_perr,
  input  logic        PARITYSEL,
  output logic [31:0] HADDR,
  output logic [1:0]  HTRANS,
  output logic        HWRITE,
  output logic [2:0]  HSIZE,
  output logic [31:0] HWDATA,
  input  logic        HREADY,
  input  logic [31:0] HRDATA,
  input  logic        HRESP
);

  localparam logic [1:0] TRANS_IDLE   = 2'b00;
  localparam logic [1:0] TRANS_NONSEQ = 2'b10;

  logic        ap_valid_q, ap_valid_d;
  logic [31:0] haddr_q, haddr_d;
  logic        hwrite_q, hwrite_d;
  logic [31:0] ap_wdata_q, ap_wdata_d;
  logic        dp_valid_q, dp_valid_d;
  logic        dp_write_q, dp_write_d;
  logic [31:0] hwdata_q, hwdata_d;
  logic        cancel_pending_q, cancel_pending_d;
  logic        cancel_fire_q, cancel_fire_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic [31:0] rsp_rdata_q, rsp_rdata_d;
  logic        rsp_err_q, rsp_err_d;
  logic        rsp_perr_q, rsp_perr_d;

  logic accept, ap_done, dp_ok, dp_err_first, dp_err_last;

  assign cmd_ready    = (!ap_valid_q || HREADY) && !(HRESP && !HREADY) && !cancel_pending_q;
  assign accept       = cmd_valid && cmd_ready;
  assign ap_done      = ap_valid_q && HREADY;
  assign dp_ok        = dp_valid_q && HREADY && !HRESP;
  assign dp_err_first = dp_valid_q && HRESP && !HREADY;
  assign dp_err_last  = dp_valid_q && HRESP && HREADY;

  always_comb begin
    ap_valid_d       = ap_valid_q;
    haddr_d          = haddr_q;
    hwrite_d         = hwrite_q;
    ap_wdata_d       = ap_wdata_q;
    dp_valid_d       = dp_valid_q;
    dp_write_d       = dp_write_q;
    hwdata_d         = hwdata_q;
    cancel_pending_d = cancel_pending_q;

    if (ap_done) begin
      ap_valid_d = 1'b0;
      dp_valid_d = 1'b1;
      dp_write_d = hwrite_q;
      hwdata_d   = hwrite_q ? ap_wdata_q : 32'h0;
    end else if (dp_valid_q && HREADY) begin
      dp_valid_d = 1'b0;
    end

    // An ERROR on the data phase kills whatever sits in the address phase.
    if (dp_err_first && ap_valid_q) begin
      ap_valid_d       = 1'b0;
      cancel_pending_d = 1'b1;
    end

    if (accept) begin
      ap_valid_d = 1'b1;
      haddr_d    = BASE_ADDR + cmd_addr;
      hwrite_d   = cmd_write;
      ap_wdata_d = cmd_wdata;
    end

    // The cancelled command answers one cycle after the erroring transfer.
    cancel_fire_d = dp_err_last && cancel_pending_q;
    if (cancel_fire_q) begin
      cancel_pending_d = 1'b0;
    end
  end

  always_comb begin
    rsp_valid_d = dp_ok || dp_err_last || cancel_fire_q;
    rsp_err_d   = dp_err_last || cancel_fire_q;
    rsp_rdata_d = (dp_ok && !dp_write_q) ? HRDATA : 32'h0;
`ifdef RD_PARITY_CHECK_EN
    rsp_perr_d  = dp_ok && !dp_write_q &&
                  (HRDATA[16] != (PARITYSEL ? ~^HRDATA[15:0] : ^HRDATA[15:0]));
`else
    rsp_perr_d  = 1'b0;
`endif
  end

`ifndef RD_PARITY_CHECK_EN
  logic unused_paritysel;
  assign unused_paritysel = PARITYSEL;
`endif

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      ap_valid_q       <= 1'b0;
      haddr_q          <= 32'h0;
      hwrite_q         <= 1'b0;
      ap_wdata_q       <= 32'h0;
      dp_valid_q       <= 1'b0;
      dp_write_q       <= 1'b0;
      hwdata_q         <= 32'h0;
      cancel_pending_q <= 1'b0;
      cancel_fire_q    <= 1'b0;
      rsp_valid_q      <= 1'b0;
      rsp_rdata_q      <= 32'h0;
      rsp_err_q        <= 1'b0;
      rsp_perr_q       <= 1'b0;
    end else begin
      ap_valid_q       <= ap_valid_d;
      haddr_q          <= haddr_d;
      hwrite_q         <= hwrite_d;
      ap_wdata_q       <= ap_wdata_d;
      dp_valid_q       <= dp_valid_d;
      dp_write_q       <= dp_write_d;
      hwdata_q         <= hwdata_d;
      cancel_pending_q <= cancel_pending_d;
      cancel_fire_q    <= cancel_fire_d;
      rsp_valid_q      <= rsp_valid_d;
      rsp_rdata_q      <= rsp_rdata_d;
      rsp_err_q        <= rsp_err_d;
      rsp_perr_q       <= rsp_perr_d;
    end
  end

  // HTRANS follows the address slot so reset forces IDLE without waiting for a clock.
  assign HTRANS    = ap_valid_q ? TRANS_NONSEQ : TRANS_IDLE;
  assign HADDR     = haddr_q;
  assign HWRITE    = hwrite_q;
  assign HSIZE     = HSIZE_WORD;
  assign HWDATA    = hwdata_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;
  assign rsp_perr  = rsp_perr_q;

endmodule

// File: tb/tb_ahb_lite_master.sv
// Directed self-checking bench for ahb_lite_master (BASE_ADDR chosen so one address wraps to zero).
module tb_ahb_lite_master;

   logic        HCLK = 1'b0;
   logic        HRESET;
   logic        cmdValid, cmdReady, cmdWrite;
   logic [31:0] cmdAddr, cmdWdata;
   logic        rspValid, rspErr, rspPerr;
   logic [31:0] rspRdata;
   logic        PARITYSEL;
   logic [31:0] HADDR, HWDATA, HRDATA;
   logic [1:0]  HTRANS;
   logic        HWRITE, HREADY, HRESP;
   logic [2:0]  HSIZE;

   int totalChecks = 0;
   int badChecks   = 0;

   ahb_lite_master #(.BASE_ADDR(32'hFFFF_FF00), .HSIZE_WORD(3'b010)) dut (
      .HCLK(HCLK), .HRESET(HRESET),
      .cmd_valid(cmdValid), .cmd_ready(cmdReady), .cmd_write(cmdWrite),
      .cmd_addr(cmdAddr), .cmd_wdata(cmdWdata),
      .rsp_valid(rspValid), .rsp_rdata(rspRdata), .rsp_err(rspErr), .rsp_perr(rspPerr),
      .PARITYSEL(PARITYSEL),
      .HADDR(HADDR), .HTRANS(HTRANS), .HWRITE(HWRITE), .HSIZE(HSIZE), .HWDATA(HWDATA),
      .HREADY(HREADY), .HRDATA(HRDATA), .HRESP(HRESP)
   );

   // 100 MHz bus clock
   always #5 HCLK = ~HCLK;

   // Compare one observed value against its hand-computed expectation
   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
      totalChecks++;
      if (got !== exp) begin
         badChecks++;
         $display("[TB] FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // Present one command on the valid/ready side
   task automatic applyStimulus(input logic v, input logic w, input logic [31:0] a, input logic [31:0] d);
      cmdValid = v;
      cmdWrite = w;
      cmdAddr  = a;
      cmdWdata = d;
   endtask

   // Advance one clock; state is sampled 1ns after the rising edge
   task automatic step();
      @(posedge HCLK);
      #1;
   endtask

   // Single zero-wait read whose parity result is checked
   task automatic parityRead(input logic [31:0] data, input logic psel, input logic expPerr, input string tag);
      logic wantPerr;
`ifdef RD_PARITY_CHECK_EN
      wantPerr = expPerr;
`else
      wantPerr = 1'b0;
`endif
      applyStimulus(1, 0, 32'h30, 0);
      step();
      applyStimulus(0, 0, 0, 0);
      step();
      HRDATA    = data;
      PARITYSEL = psel;
      step();
      checkOutput({tag, " valid"}, rspValid, 1);
      checkOutput({tag, " rdata"}, rspRdata, data);
      checkOutput({tag, " perr"}, rspPerr, wantPerr);
   endtask

   // Directed scenario sequence
   initial begin
      logic expPerrS1;
      HRESET = 1'b1;
      applyStimulus(0, 0, 0, 0);
      PARITYSEL = 1'b0;
      HREADY = 1'b1;
      HRESP = 1'b0;
      HRDATA = 32'h0;
      step();
      step();
      checkOutput("rst htrans", HTRANS, 0);
      checkOutput("rst haddr", HADDR, 0);
      checkOutput("rst hwrite", HWRITE, 0);
      checkOutput("rst hwdata", HWDATA, 0);
      checkOutput("rst rsp_valid", rspValid, 0);
      checkOutput("rst rsp_rdata", rspRdata, 0);
      checkOutput("rst rsp_err", rspErr, 0);
      checkOutput("rst rsp_perr", rspPerr, 0);
      checkOutput("rst cmd_ready", cmdReady, 1);
      checkOutput("hsize", HSIZE, 3'b010);
      HRESET = 1'b0;
      step();

      // Write then read
      applyStimulus(1, 1, 32'h4, 32'h1);
      #1;
      checkOutput("s1 cmd_ready", cmdReady, 1);
      step();
      checkOutput("s1 htrans w", HTRANS, 2'b10);
      checkOutput("s1 haddr w", HADDR, 32'hFFFF_FF04);
      checkOutput("s1 hwrite w", HWRITE, 1);
      applyStimulus(1, 0, 32'h0, 32'h0);
      step();
      checkOutput("s1 htrans r", HTRANS, 2'b10);
      checkOutput("s1 haddr r", HADDR, 32'hFFFF_FF00);
      checkOutput("s1 hwrite r", HWRITE, 0);
      checkOutput("s1 hwdata", HWDATA, 32'h1);
      applyStimulus(0, 0, 0, 0);
      HRDATA = 32'h0001_A5A5;
      step();
      checkOutput("s1 rsp1 valid", rspValid, 1);
      checkOutput("s1 rsp1 rdata", rspRdata, 0);
      checkOutput("s1 rsp1 err", rspErr, 0);
      checkOutput("s1 htrans idle", HTRANS, 0);
      step();
`ifdef RD_PARITY_CHECK_EN
      expPerrS1 = 1'b1;
`else
      expPerrS1 = 1'b0;
`endif
      checkOutput("s1 rsp2 valid", rspValid, 1);
      checkOutput("s1 rsp2 rdata", rspRdata, 32'h0001_A5A5);
      checkOutput("s1 rsp2 err", rspErr, 0);
      checkOutput("s1 rsp2 perr", rspPerr, expPerrS1);
      step();
      checkOutput("s1 rsp end", rspValid, 0);

      // Four back-to-back writes; first address wraps past 2^32
      for (int i = 0; i < 7; i++) begin
         if (i < 4) applyStimulus(1, 1, 32'h100 + 32'(4 * i), 32'hA0 + 32'(i));
         else       applyStimulus(0, 0, 0, 0);
         step();
         checkOutput($sformatf("s2 htrans %0d", i), HTRANS, (i < 4) ? 2 : 0);
         if (i < 4) checkOutput($sformatf("s2 haddr %0d", i), HADDR, 32'(4 * i));
         if (i >= 1 && i <= 4) checkOutput($sformatf("s2 hwdata %0d", i), HWDATA, 32'hA0 + 32'(i - 1));
         checkOutput($sformatf("s2 rsp_valid %0d", i), rspValid, (i >= 2 && i <= 5) ? 1 : 0);
         if (i >= 2 && i <= 5) begin
            checkOutput($sformatf("s2 rdata %0d", i), rspRdata, 0);
            checkOutput($sformatf("s2 perr %0d", i), rspPerr, 0);
         end
      end

      // Two reads, first stalled by two wait states
      applyStimulus(1, 0, 32'h10, 0);
      step();
      applyStimulus(1, 0, 32'h14, 0);
      step();
      applyStimulus(0, 0, 0, 0);
      HREADY = 1'b0;
      #1;
      checkOutput("s3 cmd_ready", cmdReady, 0);
      for (int i = 0; i < 2; i++) begin
         step();
         checkOutput($sformatf("s3 haddr hold %0d", i), HADDR, 32'hFFFF_FF14);
         checkOutput($sformatf("s3 htrans hold %0d", i), HTRANS, 2'b10);
         checkOutput($sformatf("s3 no rsp %0d", i), rspValid, 0);
         checkOutput($sformatf("s3 cmd_ready %0d", i), cmdReady, 0);
      end
      HREADY = 1'b1;
      HRDATA = 32'h1111_0000;
      step();
      checkOutput("s3 rsp1 valid", rspValid, 1);
      checkOutput("s3 rsp1 rdata", rspRdata, 32'h1111_0000);
      HRDATA = 32'h2222_0000;
      step();
      checkOutput("s3 rsp2 valid", rspValid, 1);
      checkOutput("s3 rsp2 rdata", rspRdata, 32'h2222_0000);
      step();
      checkOutput("s3 rsp end", rspValid, 0);

      // ERROR on write A while read B waits in its address phase
      applyStimulus(1, 1, 32'h20, 32'hDEAD);
      step();
      applyStimulus(1, 0, 32'h24, 0);
      step();
      applyStimulus(0, 0, 0, 0);
      HRESP = 1'b1;
      HREADY = 1'b0;
      HRDATA = 32'hFFFF_FFFF;
      #1;
      checkOutput("s4 cmd_ready err1", cmdReady, 0);
      step();
      checkOutput("s4 htrans idle", HTRANS, 0);
      checkOutput("s4 no rsp", rspValid, 0);
      HREADY = 1'b1;
      #1;
      checkOutput("s4 cmd_ready err2", cmdReady, 0);
      step();
      checkOutput("s4 rspA valid", rspValid, 1);
      checkOutput("s4 rspA err", rspErr, 1);
      checkOutput("s4 rspA rdata", rspRdata, 0);
      HRESP = 1'b0;
      step();
      checkOutput("s4 rspB valid", rspValid, 1);
      checkOutput("s4 rspB err", rspErr, 1);
      checkOutput("s4 rspB rdata", rspRdata, 0);
      checkOutput("s4 cmd_ready after", cmdReady, 1);
      step();
      checkOutput("s4 rsp end", rspValid, 0);

      // Read parity
      parityRead(32'h0000_0001, 1'b0, 1'b1, "s5 even bad");
      parityRead(32'h0001_0001, 1'b0, 1'b0, "s5 even ok");
      parityRead(32'h0000_0000, 1'b1, 1'b1, "s5 odd bad");
      parityRead(32'h0001_0000, 1'b1, 1'b0, "s5 odd ok");
      PARITYSEL = 1'b0;

      // Reset while a read is in its data phase and another is in address phase
      applyStimulus(1, 0, 32'h40, 0);
      step();
      applyStimulus(1, 1, 32'h44, 32'h55);
      step();
      checkOutput("s6 htrans before", HTRANS, 2'b10);
      applyStimulus(0, 0, 0, 0);
      HRESET = 1'b1;
      #1;
      checkOutput("s6 htrans async", HTRANS, 0);
      checkOutput("s6 haddr async", HADDR, 0);
      step();
      step();
      HRESET = 1'b0;
      for (int i = 0; i < 4; i++) begin
         step();
         checkOutput($sformatf("s6 no rsp %0d", i), rspValid, 0);
         checkOutput($sformatf("s6 cmd_ready %0d", i), cmdReady, 1);
         checkOutput($sformatf("s6 htrans %0d", i), HTRANS, 0);
      end

      $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
      $finish;
   end

endmodule
